dds_sweep_ctrl: RTL

Register-programmed frequency-sweep controller that drives the control inputs of the DDS signal generator (wave_select, amp_ctl, freq_ctl, min_ctl, phase_ctl).
- It holds static waveform settings written over a valid/ready config port.
- On command, it steps freq_ctl from a start word toward a stop word, holding each value for a programmable dwell.
- It sits between the key/UART command decoder and the DDS core, in the sys_clk domain.

---
 rtl/dds_pkg.sv | 56 +++++
 rtl/dds_dwell_timer.sv | 34 +++
 rtl/dds_sweep_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, FSM encoding and step arithmetic for the
// DDS frequency-sweep controller.
package dds_pkg;

    // One-hot waveform codes understood by the DDS core
    localparam logic [3:0] WAVE_SIN = 4'b0001;
    localparam logic [3:0] WAVE_SQU = 4'b0010;
    localparam logic [3:0] WAVE_TRI = 4'b0100;
    localparam logic [3:0] WAVE_SAW = 4'b1000;

    // Config register map
    localparam logic [2:0] ADDR_F_START = 3'd0;
    localparam logic [2:0] ADDR_F_STOP  = 3'd1;
    localparam logic [2:0] ADDR_F_STEP  = 3'd2;
    localparam logic [2:0] ADDR_DWELL   = 3'd3;
    localparam logic [2:0] ADDR_WAVE    = 3'd4;
    localparam logic [2:0] ADDR_AMP     = 3'd5;
    localparam logic [2:0] ADDR_PHASE   = 3'd6;
    localparam logic [2:0] ADDR_MIN     = 3'd7;

    // Reset defaults
    localparam logic [8:0] AMP_UNITY = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2
    } sweep_state_t;

    // Upward step with 33-bit headroom, clamped at the upper limit
    function automatic logic [31:0] step_up(input logic [31:0] cur,
                                            input logic [31:0] step,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum >= {1'b0, lim}) begin
            step_up = lim;
        end else begin
            step_up = sum[31:0];
        end
    endfunction

    // Downward step; a borrow or a result at/below the lower limit clamps
    function automatic logic [31:0] step_down(input logic [31:0] cur,
                                              input logic [31:0] step,
                                              input logic [31:0] lim);
        logic [32:0] dif;
        dif = {1'b0, cur} - {1'b0, step};
        if (dif[32] || (dif[31:0] <= lim)) begin
            step_down = lim;
        end else begin
            step_down = dif[31:0];
        end
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter holding the number of cycles left
// for the current frequency value. expire is high in the last such cycle.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};

    logic [DWELL_W-1:0] cnt_r;

    assign expire = en & (cnt_r == CNT_ONE);

    // Count register: load has priority, otherwise count down while enabled
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: register-programmed frequency sweep driving the DDS core.
// Static settings (wave/amp/phase/min) update any time; sweep registers
// (f_start/f_stop/f_step/dwell) are writable only while idle.
// Build option: define DDS_SWEEP_TRIANGLE_EN for a triangle sweep
// (up then down); without it the sweep is a sawtooth.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        start,
    input  logic        stop,
    output logic        busy,
    output logic        step_pulse,
    output logic [3:0]  wave_select,
    output logic [8:0]  amp_ctl,
    output logic [31:0] freq_ctl,
    output logic [31:0] min_ctl,
    output logic [11:0] phase_ctl
);

    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

    logic [31:0]        f_start_r, f_stop_r, f_step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [3:0]         wave_r;
    logic [8:0]         amp_r;
    logic [11:0]        phase_r;
    logic [31:0]        min_r;
    logic [31:0]        freq_r;
    logic               step_pulse_r;
    logic               busy_r;

    sweep_state_t       state_r, state_nxt_s;
    logic [31:0]        freq_nxt_s, step_val_s;
    logic               step_nxt_s;
    logic               tmr_load_s, tmr_en_s, expire_s;
    logic               cfg_wr_s;
    logic [DWELL_W-1:0] dwell_eff_s;
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic               dir_up_r, dir_up_nxt_s, dir_calc_s;
`endif

    assign cfg_ready   = ~busy_r | cfg_addr[2];
    assign cfg_wr_s    = cfg_valid & cfg_ready;
    assign dwell_eff_s = (dwell_r == DWELL_ZERO) ? DWELL_ONE : dwell_r;
    assign tmr_en_s    = (state_r != ST_IDLE);

    assign busy        = busy_r;
    assign step_pulse  = step_pulse_r;
    assign freq_ctl    = freq_r;
    assign wave_select = wave_r;
    assign amp_ctl     = amp_r;
    assign phase_ctl   = phase_r;
    assign min_ctl     = min_r;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (tmr_load_s),
        .en        (tmr_en_s),
        .load_val  (dwell_eff_s),
        .expire    (expire_s)
    );

    // Config register file; the handshake already blocks sweep registers while busy
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            f_start_r <= 32'd0;
            f_stop_r  <= 32'd0;
            f_step_r  <= 32'd0;
            dwell_r   <= DWELL_ONE;
            wave_r    <= WAVE_SIN;
            amp_r     <= AMP_UNITY;
            phase_r   <= 12'd0;
            min_r     <= 32'd0;
        end else if (cfg_wr_s) begin
            case (cfg_addr)
                ADDR_F_START: f_start_r <= cfg_wdata;
                ADDR_F_STOP:  f_stop_r  <= cfg_wdata;
                ADDR_F_STEP:  f_step_r  <= cfg_wdata;
                ADDR_DWELL:   dwell_r   <= cfg_wdata[DWELL_W-1:0];
                ADDR_WAVE:    wave_r    <= cfg_wdata[3:0];
                ADDR_AMP:     amp_r     <= cfg_wdata[8:0];
                ADDR_PHASE:   phase_r   <= cfg_wdata[11:0];
                ADDR_MIN:     min_r     <= cfg_wdata;
                default:      min_r     <= min_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: stop beats start, start beats dwell expiry
    always_comb begin
        state_nxt_s = state_r;
        if (stop) begin
            state_nxt_s = ST_IDLE;
        end else if (start) begin
            state_nxt_s = ST_DWELL;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_DWELL: state_nxt_s = expire_s ? ST_STEP : ST_DWELL;
                ST_STEP:  state_nxt_s = expire_s ? ST_STEP : ST_DWELL;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Next frequency value applied when the current dwell expires
    always_comb begin
        step_val_s = freq_r;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_calc_s = dir_up_r;
`endif
        if (f_start_r >= f_stop_r) begin
            step_val_s = f_start_r;
        end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
            if (dir_up_r) begin
                if (freq_r == f_stop_r) begin
                    dir_calc_s = 1'b0;
                    step_val_s = step_down(freq_r, f_step_r, f_start_r);
                end else begin
                    step_val_s = step_up(freq_r, f_step_r, f_stop_r);
                end
            end else begin
                if (freq_r == f_start_r) begin
                    dir_calc_s = 1'b1;
                    step_val_s = step_up(freq_r, f_step_r, f_stop_r);
                end else begin
                    step_val_s = step_down(freq_r, f_step_r, f_start_r);
                end
            end
`else
            if (freq_r == f_stop_r) begin
                step_val_s = f_start_r;
            end else begin
                step_val_s = step_up(freq_r, f_step_r, f_stop_r);
            end
`endif
        end
    end

    // FSM outputs: next values for the registered sweep outputs and timer load
    always_comb begin
        freq_nxt_s   = freq_r;
        step_nxt_s   = 1'b0;
        tmr_load_s   = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_up_nxt_s = dir_up_r;
`endif
        if (stop) begin
            freq_nxt_s = freq_r;
        end else if (start) begin
            freq_nxt_s   = f_start_r;
            tmr_load_s   = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_up_nxt_s = 1'b1;
`endif
        end else if (tmr_en_s && expire_s) begin
            freq_nxt_s   = step_val_s;
            step_nxt_s   = 1'b1;
            tmr_load_s   = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_up_nxt_s = dir_calc_s;
`endif
        end else begin
            freq_nxt_s = freq_r;
        end
    end

    // Registered sweep outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            freq_r       <= 32'd0;
            step_pulse_r <= 1'b0;
            busy_r       <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_up_r     <= 1'b1;
`endif
        end else begin
            freq_r       <= freq_nxt_s;
            step_pulse_r <= step_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
`ifdef DDS_SWEEP_TRIANGLE_EN
            dir_up_r     <= dir_up_nxt_s;
`endif
        end
    end

endmodule
